// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
// Avalon-MM style command/response bundle. It is used three times around the
// arbiter: once per requester and once for the shared SDRAM master.
//
// Signals
//   address, read, write, writedata : command, driven by the master side
//   waitrequest                     : stall, driven by the slave side
//   readdata, readdatavalid         : read response, driven by the slave side
//
// Modports
//   master : the side that issues commands
//   slave  : the side that accepts commands and returns read data
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Shares one SDRAM Avalon-MM master between two requesters: r0 (notch-filter
// result writer) and r1 (sample prefetch/DMA engine). Round-robin arbitration,
// one command on the master at a time, pipelined reads with up to
// MAX_PENDING outstanding. Read data is routed back through an in-order tag
// FIFO holding the id of the requester that issued each read.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   r0, r1       : requester ports (slave modport of sdram_port_arbiter_if)
//   m            : SDRAM master port (master modport), command is registered
//   pending      : number of reads accepted by the slave and not yet returned
//   err          : sticky protocol error (orphan read data, or read+write)
//   state_dbg    : 1 while a command is being presented on m (ISSUE)
//
// Handshake: a requester presents a command by raising read or write and
// holds address/writedata/strobe steady while its waitrequest is 1. The
// command is taken at the rising edge of a cycle in which its waitrequest
// is 0; that happens only while the command is on m and the slave's
// m.waitrequest is 0. Read data returns in order with readdatavalid.
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4,
   parameter int PEND_W      = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   sdram_port_arbiter_if.slave  r0,
   sdram_port_arbiter_if.slave  r1,
   sdram_port_arbiter_if.master m,
   output logic [PEND_W:0]      pending,
   output logic                 err,
   output logic                 state_dbg
);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   localparam logic [PEND_W:0] PEND_MAX = (PEND_W+1)'(MAX_PENDING);

   state_t            state;
   state_t            state_nxt;
   logic              grant;
   logic              grant_nxt;
   logic              last_grant;
   logic              do_grant;

   logic              tag_mem [MAX_PENDING];
   logic [PEND_W-1:0] wr_ptr;
   logic [PEND_W-1:0] rd_ptr;
   logic              head;

   logic              rd0;
   logic              rd1;
   logic              elig0;
   logic              elig1;
   logic              room;
   logic              pop;
   logic              accept;
   logic              push;

   logic [ADDR_W-1:0] sel_address;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_read;
   logic              sel_write;

   // read together with write is treated as a plain write
   assign rd0    = r0.read & ~r0.write;
   assign rd1    = r1.read & ~r1.write;

   // a return frees a slot in the same cycle, so a read may still go out
   // when the pending count is at its limit
   assign pop    = m.readdatavalid && (pending != '0);
   assign room   = (pending < PEND_MAX) || pop;
   assign elig0  = r0.write | (rd0 & room);
   assign elig1  = r1.write | (rd1 & room);

   assign accept = (state == ISSUE) && !m.waitrequest;
   assign push   = accept && m.read;
   assign head   = tag_mem[rd_ptr];

   // ---------------- FSM: next state and grant decision ----------------
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      do_grant  = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 || elig1) begin
               do_grant  = 1'b1;
               state_nxt = ISSUE;
               if (elig0 && elig1) grant_nxt = ~last_grant;
               else                grant_nxt = elig1;
            end
         end
         ISSUE: begin
            if (!m.waitrequest) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // command of the requester about to be granted
   always_comb begin
      sel_address   = r0.address;
      sel_writedata = r0.writedata;
      sel_read      = rd0;
      sel_write     = r0.write;
      if (grant_nxt) begin
         sel_address   = r1.address;
         sel_writedata = r1.writedata;
         sel_read      = rd1;
         sel_write     = r1.write;
      end
   end

   // ---------------- state, master command, tag FIFO, status ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         m.address   <= '0;
         m.read      <= 1'b0;
         m.write     <= 1'b0;
         m.writedata <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pending     <= '0;
         err         <= 1'b0;
      end else begin
         state <= state_nxt;

         if (do_grant) begin
            grant       <= grant_nxt;
            last_grant  <= grant_nxt;
            m.address   <= sel_address;
            m.read      <= sel_read;
            m.write     <= sel_write;
            m.writedata <= sel_writedata;
         end else if (accept) begin
            m.read  <= 1'b0;
            m.write <= 1'b0;
         end

         if (push) begin
            tag_mem[wr_ptr] <= grant;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      pending <= pending + 1'b1;
         else if (pop && !push) pending <= pending - 1'b1;

         if ((m.readdatavalid && pending == '0) ||
             (r0.read && r0.write) || (r1.read && r1.write))
            err <= 1'b1;
      end
   end

   // ---------------- requester side outputs ----------------
   assign r0.waitrequest   = !(accept && grant == 1'b0);
   assign r1.waitrequest   = !(accept && grant == 1'b1);
   assign r0.readdata      = m.readdata;
   assign r1.readdata      = m.readdata;
   assign r0.readdatavalid = pop && (head == 1'b0);
   assign r1.readdatavalid = pop && (head == 1'b1);
   assign state_dbg        = (state == ISSUE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Self-checking bench for sdram_port_arbiter. Inputs are driven just after
// the falling edge and outputs sampled 1 ns later, so combinational outputs
// reflect the inputs used at the next rising edge and registered outputs
// reflect the previous rising edge.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;
   localparam int ADDR_W      = 24;
   localparam int DATA_W      = 32;
   localparam int MAX_PENDING = 4;
   localparam int PEND_W      = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [PEND_W:0]   pending;
   logic              err;
   logic              state_dbg;

   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();
   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

   sdram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .PEND_W(PEND_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .r0        (r0_if.slave),
      .r1        (r1_if.slave),
      .m         (m_if.master),
      .pending   (pending),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // reference model: requester id of every read the slave has accepted and
   // not yet answered, oldest first
   logic [0:0] exp_q[$];

   // ---------------- driver tasks ----------------
   task automatic set_req(input int id, input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (id == 0) begin
         r0_if.read = rd; r0_if.write = wr; r0_if.address = a; r0_if.writedata = d;
      end else begin
         r1_if.read = rd; r1_if.write = wr; r1_if.address = a; r1_if.writedata = d;
      end
   endtask

   task automatic clear_inputs;
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      m_if.waitrequest   = 1'b0;
      m_if.readdata      = '0;
      m_if.readdatavalid = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic wait_of(input int id);
      return (id == 0) ? r0_if.waitrequest : r1_if.waitrequest;
   endfunction

   // present one command until it is taken (bounded), then withdraw it
   task automatic issue_cmd(input int id, input logic rd, input logic wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output logic ok, output logic saw_rd, output logic saw_wr);
      ok = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         set_req(id, rd, wr, a, d);
         #1;
         if (!wait_of(id)) begin
            ok = 1'b1; saw_rd = m_if.read; saw_wr = m_if.write;
         end
      end
      @(negedge clk);
      set_req(id, 1'b0, 1'b0, '0, '0);
      if (ok && rd && !wr) exp_q.push_back(id[0]);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      do_reset();
      #1;
      total++; if (m_if.read !== 1'b0) $display("FAIL reset_m_read got %b exp 0", m_if.read); else passed++;
      total++; if (m_if.write !== 1'b0) $display("FAIL reset_m_write got %b exp 0", m_if.write); else passed++;
      total++; if (m_if.address !== '0) $display("FAIL reset_m_address got %h exp 0", m_if.address); else passed++;
      total++; if (m_if.writedata !== '0) $display("FAIL reset_m_writedata got %h exp 0", m_if.writedata); else passed++;
      total++; if (pending !== '0) $display("FAIL reset_pending got %0d exp 0", pending); else passed++;
      total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
      total++; if ({r0_if.waitrequest, r1_if.waitrequest} !== 2'b11)
         $display("FAIL reset_waitrequest got %b exp 11", {r0_if.waitrequest, r1_if.waitrequest}); else passed++;
      total++; if (state_dbg !== 1'b0) $display("FAIL reset_state got %b exp 0", state_dbg); else passed++;
   endtask

   task automatic test_single_write;
      logic accepted = 1'b0;
      int   hi = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         set_req(0, 1'b0, !accepted, 24'h000100, 32'hDEADBEEF);
         m_if.waitrequest = 1'b0;
         #1;
         if (c == 0) begin
            total++; if (m_if.write !== 1'b0) $display("FAIL single_write_early got %b exp 0", m_if.write); else passed++;
         end
         if (c == 1) begin
            total++; if (m_if.write !== 1'b1) $display("FAIL single_write_latency got %b exp 1", m_if.write); else passed++;
         end
         if (m_if.write) begin
            hi++;
            total++; if (m_if.address !== 24'h000100) $display("FAIL single_write_addr got %h exp 000100", m_if.address); else passed++;
            total++; if (m_if.writedata !== 32'hDEADBEEF) $display("FAIL single_write_data got %h exp deadbeef", m_if.writedata); else passed++;
            total++; if (r0_if.waitrequest !== 1'b0) $display("FAIL single_write_wait got %b exp 0", r0_if.waitrequest); else passed++;
         end
         if (!r0_if.waitrequest) accepted = 1'b1;
      end
      total++; if (hi !== 1) $display("FAIL single_write_width got %0d cycles exp 1", hi); else passed++;
   endtask

   task automatic test_round_robin;
      int order[6];
      int n = 0;
      logic [DATA_W-1:0] d0 = 32'hA000_0000;
      logic [DATA_W-1:0] d1 = 32'hB000_0000;
      do_reset();
      for (int k = 0; k < 6; k++) order[k] = -1;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         set_req(0, 1'b0, 1'b1, 24'h001000, d0);
         set_req(1, 1'b0, 1'b1, 24'h002000, d1);
         m_if.waitrequest = 1'($urandom_range(0, 1));
         #1;
         total++; if (!r0_if.waitrequest && !r1_if.waitrequest)
            $display("FAIL rr_double_accept got both exp one"); else passed++;
         if (!r0_if.waitrequest) begin
            total++; if (m_if.writedata !== d0) $display("FAIL rr_data0 got %h exp %h", m_if.writedata, d0); else passed++;
            order[n] = 0; n++; d0++;
         end else if (!r1_if.waitrequest) begin
            total++; if (m_if.writedata !== d1) $display("FAIL rr_data1 got %h exp %h", m_if.writedata, d1); else passed++;
            order[n] = 1; n++; d1++;
         end
      end
      @(negedge clk);
      clear_inputs();
      total++; if (n !== 6) $display("FAIL rr_count got %0d exp 6", n); else passed++;
      for (int k = 0; k < 6; k++) begin
         total++; if (order[k] !== k % 2) $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], k % 2); else passed++;
      end
   endtask

   task automatic test_pending_limit;
      logic ok, sr, sw;
      logic got = 1'b0;
      logic [0:0] hid;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         issue_cmd(1, 1'b1, 1'b0, ADDR_W'(24'h000200 + k), '0, ok, sr, sw);
         total++; if (ok !== 1'b1 || sr !== 1'b1) $display("FAIL limit_read%0d got ok=%b rd=%b exp 1 1", k, ok, sr); else passed++;
      end
      @(negedge clk);
      #1;
      total++; if (pending !== 3'd4) $display("FAIL limit_pending got %0d exp 4", pending); else passed++;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         set_req(1, 1'b1, 1'b0, 24'h000204, '0);
         #1;
         total++; if (r1_if.waitrequest !== 1'b1 || m_if.read !== 1'b0)
            $display("FAIL limit_stall got wait=%b m_read=%b exp 1 0", r1_if.waitrequest, m_if.read); else passed++;
      end
      for (int c = 0; c < 6 && !got; c++) begin
         @(negedge clk);
         set_req(1, 1'b1, 1'b0, 24'h000204, '0);
         set_req(0, 1'b0, 1'b1, 24'h000300, 32'h0000_5555);
         #1;
         if (!r0_if.waitrequest) begin
            got = 1'b1;
            total++; if (m_if.write !== 1'b1 || m_if.address !== 24'h000300)
               $display("FAIL limit_write_cmd got w=%b a=%h exp 1 000300", m_if.write, m_if.address); else passed++;
         end
         total++; if (r1_if.waitrequest !== 1'b1) $display("FAIL limit_read5_taken got wait=%b exp 1", r1_if.waitrequest); else passed++;
      end
      total++; if (got !== 1'b1) $display("FAIL limit_write_grant got %b exp 1", got); else passed++;
      @(negedge clk);
      clear_inputs();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         m_if.readdatavalid = 1'b1;
         m_if.readdata      = 32'hA0 + k;
         #1;
         hid = exp_q.pop_front();
         total++; if ({r1_if.readdatavalid, r0_if.readdatavalid} !== {hid == 1'b1, hid == 1'b0})
            $display("FAIL limit_route%0d got r1=%b r0=%b exp id %0d", k, r1_if.readdatavalid, r0_if.readdatavalid, hid); else passed++;
         total++; if (r1_if.readdata !== 32'hA0 + k) $display("FAIL limit_data%0d got %h exp %h", k, r1_if.readdata, 32'hA0 + k); else passed++;
      end
      @(negedge clk);
      m_if.readdatavalid = 1'b0;
      #1;
      total++; if (pending !== 3'd0) $display("FAIL limit_drain got %0d exp 0", pending); else passed++;
   endtask

   task automatic test_interleaved_reads;
      logic ok, sr, sw;
      logic [0:0] hid;
      logic [DATA_W-1:0] rsp[3];
      rsp[0] = 32'h11; rsp[1] = 32'h22; rsp[2] = 32'h33;
      do_reset();
      issue_cmd(0, 1'b1, 1'b0, 24'h000010, '0, ok, sr, sw);
      total++; if (ok !== 1'b1) $display("FAIL ilv_read_a got %b exp 1", ok); else passed++;
      issue_cmd(1, 1'b1, 1'b0, 24'h000020, '0, ok, sr, sw);
      total++; if (ok !== 1'b1) $display("FAIL ilv_read_b got %b exp 1", ok); else passed++;
      issue_cmd(0, 1'b1, 1'b0, 24'h000030, '0, ok, sr, sw);
      total++; if (ok !== 1'b1) $display("FAIL ilv_read_c got %b exp 1", ok); else passed++;
      @(negedge clk);
      #1;
      total++; if (pending !== 3'd3) $display("FAIL ilv_pending got %0d exp 3", pending); else passed++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         m_if.readdatavalid = 1'b1;
         m_if.readdata      = rsp[k];
         #1;
         hid = exp_q.pop_front();
         total++; if ({r1_if.readdatavalid, r0_if.readdatavalid} !== {hid == 1'b1, hid == 1'b0})
            $display("FAIL ilv_route%0d got r1=%b r0=%b exp id %0d", k, r1_if.readdatavalid, r0_if.readdatavalid, hid); else passed++;
         total++; if ((hid ? r1_if.readdata : r0_if.readdata) !== rsp[k])
            $display("FAIL ilv_data%0d got %h exp %h", k, hid ? r1_if.readdata : r0_if.readdata, rsp[k]); else passed++;
      end
      @(negedge clk);
      m_if.readdatavalid = 1'b0;
   endtask

   task automatic test_waitrequest_hold;
      int   seen = 0;
      int   acc_at = -1;
      logic accepted = 1'b0;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (m_if.write) seen++;
         set_req(0, 1'b0, !accepted, 24'h000400, 32'h1234_5678);
         m_if.waitrequest = (seen <= 5);
         #1;
         if (m_if.write) begin
            total++; if (m_if.address !== 24'h000400 || m_if.writedata !== 32'h1234_5678)
               $display("FAIL hold_stable got a=%h d=%h exp 000400 12345678", m_if.address, m_if.writedata); else passed++;
            total++; if (r0_if.waitrequest !== (seen != 6))
               $display("FAIL hold_wait cycle %0d got %b exp %b", seen, r0_if.waitrequest, seen != 6); else passed++;
         end
         if (!r0_if.waitrequest) begin accepted = 1'b1; acc_at = seen; end
      end
      total++; if (seen !== 6) $display("FAIL hold_cycles got %0d exp 6", seen); else passed++;
      total++; if (acc_at !== 6) $display("FAIL hold_accept_cycle got %0d exp 6", acc_at); else passed++;
   endtask

   task automatic test_errors;
      logic ok, sr, sw;
      do_reset();
      @(negedge clk);
      m_if.readdatavalid = 1'b1;
      m_if.readdata      = 32'h55;
      #1;
      total++; if ({r0_if.readdatavalid, r1_if.readdatavalid} !== 2'b00)
         $display("FAIL orphan_valid got %b exp 00", {r0_if.readdatavalid, r1_if.readdatavalid}); else passed++;
      @(negedge clk);
      m_if.readdatavalid = 1'b0;
      #1;
      total++; if (err !== 1'b1) $display("FAIL orphan_err got %b exp 1", err); else passed++;
      total++; if (pending !== 3'd0) $display("FAIL orphan_pending got %0d exp 0", pending); else passed++;
      do_reset();
      #1;
      total++; if (err !== 1'b0 || pending !== 3'd0 || m_if.read !== 1'b0)
         $display("FAIL err_reset got err=%b pend=%0d rd=%b exp 0 0 0", err, pending, m_if.read); else passed++;

      // read and write together behaves as a write and flags an error
      issue_cmd(1, 1'b1, 1'b1, 24'h000500, 32'h77, ok, sr, sw);
      total++; if (ok !== 1'b1 || sw !== 1'b1 || sr !== 1'b0)
         $display("FAIL rdwr_cmd got ok=%b w=%b r=%b exp 1 1 0", ok, sw, sr); else passed++;
      #1;
      total++; if (err !== 1'b1 || pending !== 3'd0)
         $display("FAIL rdwr_err got err=%b pend=%0d exp 1 0", err, pending); else passed++;

      // reset with one read outstanding and another on the master
      do_reset();
      issue_cmd(0, 1'b1, 1'b0, 24'h000600, '0, ok, sr, sw);
      @(negedge clk);
      m_if.waitrequest = 1'b1;
      set_req(1, 1'b1, 1'b0, 24'h000700, '0);
      @(negedge clk);
      #1;
      total++; if (m_if.read !== 1'b1 || pending !== 3'd1)
         $display("FAIL midcmd_setup got rd=%b pend=%0d exp 1 1", m_if.read, pending); else passed++;
      do_reset();
      #1;
      total++; if (m_if.read !== 1'b0 || pending !== 3'd0 || r1_if.waitrequest !== 1'b1)
         $display("FAIL midcmd_reset got rd=%b pend=%0d wait=%b exp 0 0 1", m_if.read, pending, r1_if.waitrequest); else passed++;
      @(negedge clk);
      m_if.readdatavalid = 1'b1;
      #1;
      total++; if ({r0_if.readdatavalid, r1_if.readdatavalid} !== 2'b00)
         $display("FAIL abandoned_tag got %b exp 00", {r0_if.readdatavalid, r1_if.readdatavalid}); else passed++;
      @(negedge clk);
      m_if.readdatavalid = 1'b0;
      #1;
      total++; if (err !== 1'b1) $display("FAIL abandoned_err got %b exp 1", err); else passed++;
   endtask

   task automatic test_random;
      logic              cv[2];
      logic              crd[2];
      logic [ADDR_W-1:0] ca[2];
      logic [DATA_W-1:0] cd[2];
      int                oth[2];
      logic              acc[2];
      logic              rdv;
      logic [DATA_W-1:0] rdata;
      logic [0:0]        hid;
      do_reset();
      for (int i = 0; i < 2; i++) begin cv[i] = 1'b0; crd[i] = 1'b0; ca[i] = '0; cd[i] = '0; oth[i] = 0; end
      for (int c = 0; c < 3500; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!cv[i] && c < 3000 && $urandom_range(0, 99) < 50) begin
               cv[i] = 1'b1; crd[i] = 1'($urandom_range(0, 1));
               ca[i] = ADDR_W'($urandom); cd[i] = $urandom; oth[i] = 0;
            end
         end
         set_req(0, cv[0] & crd[0], cv[0] & ~crd[0], ca[0], cd[0]);
         set_req(1, cv[1] & crd[1], cv[1] & ~crd[1], ca[1], cd[1]);
         m_if.waitrequest = ($urandom_range(0, 99) < 30);
         rdv   = (exp_q.size() != 0) && ($urandom_range(0, 99) < ((c < 3000) ? 40 : 90));
         rdata = $urandom;
         m_if.readdatavalid = rdv;
         m_if.readdata      = rdata;
         #1;

         total++; if (pending !== 3'(exp_q.size())) $display("FAIL rnd_pending got %0d exp %0d", pending, exp_q.size()); else passed++;
         total++; if (err !== 1'b0) $display("FAIL rnd_err got %b exp 0", err); else passed++;

         acc[0] = !r0_if.waitrequest;
         acc[1] = !r1_if.waitrequest;
         total++; if ((acc[0] | acc[1]) !== ((m_if.read | m_if.write) & ~m_if.waitrequest) || (acc[0] & acc[1]))
            $display("FAIL rnd_accept got acc=%b%b exp cmd=%b", acc[1], acc[0], (m_if.read | m_if.write) & ~m_if.waitrequest); else passed++;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               total++; if (!cv[i] || m_if.read !== crd[i] || m_if.write !== !crd[i] || m_if.address !== ca[i] ||
                            (!crd[i] && m_if.writedata !== cd[i]))
                  $display("FAIL rnd_cmd%0d got r=%b w=%b a=%h d=%h exp r=%b a=%h d=%h", i, m_if.read, m_if.write,
                           m_if.address, m_if.writedata, crd[i], ca[i], cd[i]); else passed++;
               // a waiting write from the other side lets this side through at most once
               if (cv[1-i] && !crd[1-i]) begin
                  oth[1-i]++;
                  total++; if (oth[1-i] > 1) $display("FAIL rnd_fair%0d got %0d grants exp <=1", 1-i, oth[1-i]); else passed++;
               end
            end
         end

         if (rdv) begin
            hid = exp_q.pop_front();
            total++; if ({r1_if.readdatavalid, r0_if.readdatavalid} !== {hid == 1'b1, hid == 1'b0})
               $display("FAIL rnd_route got r1=%b r0=%b exp id %0d", r1_if.readdatavalid, r0_if.readdatavalid, hid); else passed++;
            total++; if ((hid ? r1_if.readdata : r0_if.readdata) !== rdata)
               $display("FAIL rnd_rdata got %h exp %h", hid ? r1_if.readdata : r0_if.readdata, rdata); else passed++;
         end else begin
            total++; if ({r1_if.readdatavalid, r0_if.readdatavalid} !== 2'b00)
               $display("FAIL rnd_spurious_valid got %b exp 00", {r1_if.readdatavalid, r0_if.readdatavalid}); else passed++;
         end

         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               if (crd[i]) exp_q.push_back(i[0]);
               cv[i] = 1'b0;
            end
         end
      end
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if (cv[0] || cv[1] || exp_q.size() != 0 || pending !== 3'd0)
         $display("FAIL rnd_drain got cmd=%b%b q=%0d pend=%0d exp 00 0 0", cv[1], cv[0], exp_q.size(), pending); else passed++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      clear_inputs();
      test_reset();
      test_single_write();
      test_round_robin();
      test_pending_limit();
      test_interleaved_reads();
      test_waitrequest_hold();
      test_errors();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
